// File: rtl/mod_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mod_updown_counter                                           |
// | Description : Synchronous modulo-N up/down counter with load, clear and    |
// |               wrap/saturate modes, plus tc, wrap-pulse and sticky ovf.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mod_updown_counter #(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int SATURATE = 0,
    parameter int RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] data_out,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH:0]   c_MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] c_MAX     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_RST     = WIDTH'(RST_VAL);
    localparam logic             c_SAT     = (SATURATE != 0);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;
    logic             ovf_q,   ovf_d;

    logic [WIDTH:0]   w_inc_ext;
    logic [WIDTH:0]   w_dec_ext;
    logic             w_at_top;
    logic             w_at_bottom;
    logic             w_load_ok;

    // One extra bit lets the top/bottom tests fall out of the arithmetic itself:
    // the increment equals MODULUS exactly at the top, the decrement borrows at 0.
    assign w_inc_ext   = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
    assign w_dec_ext   = {1'b0, count_q} - {{WIDTH{1'b0}}, 1'b1};
    assign w_at_top    = (w_inc_ext == c_MOD_EXT);
    assign w_at_bottom = w_dec_ext[WIDTH];
    assign w_load_ok   = ({1'b0, load_val} < c_MOD_EXT);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (clear) begin
            count_d = c_RST;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = w_load_ok ? load_val : c_MAX;
        end else if (en) begin
            if (up_dn) begin
                if (w_at_top) begin
                    ovf_d = 1'b1;
                    if (!c_SAT) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = w_inc_ext[WIDTH-1:0];
                end
            end else begin
                if (w_at_bottom) begin
                    ovf_d = 1'b1;
                    if (!c_SAT) begin
                        count_d = c_MAX;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = w_dec_ext[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= c_RST;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    // Combinational so a cascaded stage can use it as its enable in the same cycle.
    assign tc       = en & ((up_dn & (count_q == c_MAX)) | (~up_dn & (count_q == '0)));
    assign data_out = count_q;
    assign wrap     = wrap_q;
    assign ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mod_updown_counter                                        |
// | Description : Directed self-checking bench for mod_updown_counter.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mod_updown_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // a: default params, b: MODULUS=6 wrap, s: SATURATE=1, c0/c1: cascade
    logic       a_en = 0, a_up = 0, a_clear = 0, a_load = 0;
    logic [2:0] a_lv = '0, a_dout;
    logic       a_tc, a_wrap, a_ovf;
    logic       b_en = 0, b_up = 0, b_clear = 0, b_load = 0;
    logic [2:0] b_lv = '0, b_dout;
    logic       b_tc, b_wrap, b_ovf;
    logic       s_en = 0, s_up = 0, s_clear = 0, s_load = 0;
    logic [2:0] s_lv = '0, s_dout;
    logic       s_tc, s_wrap, s_ovf;
    logic       c_en = 0;
    logic [2:0] c0_dout, c1_dout;
    logic       c0_tc, c0_wrap, c0_ovf, c1_tc, c1_wrap, c1_ovf;

    mod_updown_counter u_a (
        .clk(clk), .rst(rst), .en(a_en), .up_dn(a_up), .clear(a_clear), .load(a_load),
        .load_val(a_lv), .data_out(a_dout), .tc(a_tc), .wrap(a_wrap), .ovf(a_ovf));

    mod_updown_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0), .RST_VAL(0)) u_b (
        .clk(clk), .rst(rst), .en(b_en), .up_dn(b_up), .clear(b_clear), .load(b_load),
        .load_val(b_lv), .data_out(b_dout), .tc(b_tc), .wrap(b_wrap), .ovf(b_ovf));

    mod_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1), .RST_VAL(0)) u_s (
        .clk(clk), .rst(rst), .en(s_en), .up_dn(s_up), .clear(s_clear), .load(s_load),
        .load_val(s_lv), .data_out(s_dout), .tc(s_tc), .wrap(s_wrap), .ovf(s_ovf));

    mod_updown_counter u_c0 (
        .clk(clk), .rst(rst), .en(c_en), .up_dn(1'b1), .clear(1'b0), .load(1'b0),
        .load_val(3'd0), .data_out(c0_dout), .tc(c0_tc), .wrap(c0_wrap), .ovf(c0_ovf));

    mod_updown_counter u_c1 (
        .clk(clk), .rst(rst), .en(c0_tc), .up_dn(1'b1), .clear(1'b0), .load(1'b0),
        .load_val(3'd0), .data_out(c1_dout), .tc(c1_tc), .wrap(c1_wrap), .ovf(c1_ovf));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_vec++; if (a_dout !== 3'd0) begin n_err++; $display("FAIL reset_a_data got %0d want 0", a_dout); end
        n_vec++; if (a_wrap !== 1'b0) begin n_err++; $display("FAIL reset_a_wrap got %b want 0", a_wrap); end
        n_vec++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL reset_a_ovf got %b want 0", a_ovf); end
        n_vec++; if (b_dout !== 3'd0) begin n_err++; $display("FAIL reset_b_data got %0d want 0", b_dout); end
        n_vec++; if (s_dout !== 3'd0) begin n_err++; $display("FAIL reset_s_data got %0d want 0", s_dout); end
        n_vec++; if ({c1_dout, c0_dout} !== 6'd0) begin n_err++; $display("FAIL reset_cascade got %0d want 0", {c1_dout, c0_dout}); end
        rst = 1'b0;
    endtask

    task automatic test_count_up();
        logic [2:0] exp_v = 3'd0;
        logic       exp_w;
        logic       exp_o = 1'b0;
        a_en = 1'b1; a_up = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_vec++; if (a_tc !== (exp_v == 3'd7)) begin n_err++; $display("FAIL up_tc step %0d got %b want %b", i, a_tc, (exp_v == 3'd7)); end
            exp_w = (exp_v == 3'd7);
            if (exp_w) exp_o = 1'b1;
            exp_v = (exp_v == 3'd7) ? 3'd0 : exp_v + 3'd1;
            step();
            n_vec++; if (a_dout !== exp_v) begin n_err++; $display("FAIL up_data step %0d got %0d want %0d", i, a_dout, exp_v); end
            n_vec++; if (a_wrap !== exp_w) begin n_err++; $display("FAIL up_wrap step %0d got %b want %b", i, a_wrap, exp_w); end
            n_vec++; if (a_ovf !== exp_o) begin n_err++; $display("FAIL up_ovf step %0d got %b want %b", i, a_ovf, exp_o); end
        end
        a_en = 1'b0;
    endtask

    task automatic test_count_down_mod6();
        logic [2:0] exp_v = 3'd0;
        logic       exp_w;
        logic       exp_o = 1'b0;
        b_en = 1'b1; b_up = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            n_vec++; if (b_tc !== (exp_v == 3'd0)) begin n_err++; $display("FAIL dn_tc step %0d got %b want %b", i, b_tc, (exp_v == 3'd0)); end
            exp_w = (exp_v == 3'd0);
            if (exp_w) exp_o = 1'b1;
            exp_v = (exp_v == 3'd0) ? 3'd5 : exp_v - 3'd1;
            step();
            n_vec++; if (b_dout !== exp_v) begin n_err++; $display("FAIL dn_data step %0d got %0d want %0d", i, b_dout, exp_v); end
            n_vec++; if (b_wrap !== exp_w) begin n_err++; $display("FAIL dn_wrap step %0d got %b want %b", i, b_wrap, exp_w); end
            n_vec++; if (b_ovf !== exp_o) begin n_err++; $display("FAIL dn_ovf step %0d got %b want %b", i, b_ovf, exp_o); end
        end
        b_en = 1'b0;
    endtask

    task automatic test_saturate();
        logic [2:0] exp_v = 3'd6;
        logic       exp_o = 1'b0;
        s_load = 1'b1; s_lv = 3'd6;
        step();
        s_load = 1'b0;
        n_vec++; if (s_dout !== 3'd6) begin n_err++; $display("FAIL sat_load got %0d want 6", s_dout); end
        s_en = 1'b1; s_up = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++; if (s_tc !== (exp_v == 3'd7)) begin n_err++; $display("FAIL sat_tc step %0d got %b want %b", i, s_tc, (exp_v == 3'd7)); end
            if (exp_v == 3'd7) exp_o = 1'b1;
            exp_v = (exp_v == 3'd7) ? 3'd7 : exp_v + 3'd1;
            step();
            n_vec++; if (s_dout !== exp_v) begin n_err++; $display("FAIL sat_data step %0d got %0d want %0d", i, s_dout, exp_v); end
            n_vec++; if (s_wrap !== 1'b0) begin n_err++; $display("FAIL sat_wrap step %0d got %b want 0", i, s_wrap); end
            n_vec++; if (s_ovf !== exp_o) begin n_err++; $display("FAIL sat_ovf step %0d got %b want %b", i, s_ovf, exp_o); end
        end
        s_en = 1'b0; s_clear = 1'b1;
        step();
        s_clear = 1'b0;
        n_vec++; if (s_dout !== 3'd0) begin n_err++; $display("FAIL sat_clear_data got %0d want 0", s_dout); end
        n_vec++; if (s_ovf !== 1'b0) begin n_err++; $display("FAIL sat_clear_ovf got %b want 0", s_ovf); end
        s_en = 1'b1; s_up = 1'b0;
        #1;
        n_vec++; if (s_tc !== 1'b1) begin n_err++; $display("FAIL sat_dn_tc got %b want 1", s_tc); end
        step();
        s_en = 1'b0;
        n_vec++; if (s_dout !== 3'd0) begin n_err++; $display("FAIL sat_dn_hold got %0d want 0", s_dout); end
        n_vec++; if (s_ovf !== 1'b1) begin n_err++; $display("FAIL sat_dn_ovf got %b want 1", s_ovf); end
        n_vec++; if (s_wrap !== 1'b0) begin n_err++; $display("FAIL sat_dn_wrap got %b want 0", s_wrap); end
    endtask

    task automatic test_priority();
        // a sits at 2 with ovf set from the up-count wrap
        a_load = 1'b1; a_lv = 3'd5; a_clear = 1'b1; a_en = 1'b1; a_up = 1'b1;
        step();
        n_vec++; if (a_dout !== 3'd0) begin n_err++; $display("FAIL prio_clear_data got %0d want 0", a_dout); end
        n_vec++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL prio_clear_ovf got %b want 0", a_ovf); end
        a_clear = 1'b0;
        step();
        n_vec++; if (a_dout !== 3'd5) begin n_err++; $display("FAIL prio_load_data got %0d want 5", a_dout); end
        n_vec++; if (a_wrap !== 1'b0) begin n_err++; $display("FAIL prio_load_wrap got %b want 0", a_wrap); end
        a_load = 1'b0; a_en = 1'b0;
        b_load = 1'b1; b_lv = 3'd7;
        step();
        n_vec++; if (b_dout !== 3'd5) begin n_err++; $display("FAIL clamp7 got %0d want 5", b_dout); end
        b_lv = 3'd2;
        step();
        n_vec++; if (b_dout !== 3'd2) begin n_err++; $display("FAIL load2 got %0d want 2", b_dout); end
        b_lv = 3'd6;
        step();
        b_load = 1'b0;
        n_vec++; if (b_dout !== 3'd5) begin n_err++; $display("FAIL clamp6 got %0d want 5", b_dout); end
        n_vec++; if (b_ovf !== 1'b1) begin n_err++; $display("FAIL load_keeps_ovf got %b want 1", b_ovf); end
    endtask

    task automatic test_direction_hold();
        a_en = 1'b1; a_up = 1'b0;
        step();
        n_vec++; if (a_dout !== 3'd4) begin n_err++; $display("FAIL dir_down got %0d want 4", a_dout); end
        a_up = 1'b1;
        step();
        n_vec++; if (a_dout !== 3'd5) begin n_err++; $display("FAIL dir_up got %0d want 5", a_dout); end
        a_en = 1'b0;
        step();
        n_vec++; if (a_dout !== 3'd5) begin n_err++; $display("FAIL hold_data got %0d want 5", a_dout); end
        n_vec++; if (a_wrap !== 1'b0) begin n_err++; $display("FAIL hold_wrap got %b want 0", a_wrap); end
        // b holds at MODULUS-1=5: tc must follow en
        b_up = 1'b1; b_en = 1'b0;
        #1;
        n_vec++; if (b_tc !== 1'b0) begin n_err++; $display("FAIL tc_en_low got %b want 0", b_tc); end
        b_en = 1'b1;
        #1;
        n_vec++; if (b_tc !== 1'b1) begin n_err++; $display("FAIL tc_en_high got %b want 1", b_tc); end
        b_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp_v = 3'd5;
        logic       exp_w;
        a_en = 1'b1; a_up = 1'b1;
        for (int i = 0; i < 7; i++) begin
            exp_w = (exp_v == 3'd7);
            exp_v = (exp_v == 3'd7) ? 3'd0 : exp_v + 3'd1;
            step();
            n_vec++; if (a_wrap !== exp_w) begin n_err++; $display("FAIL mid_wrap step %0d got %b want %b", i, a_wrap, exp_w); end
        end
        n_vec++; if (a_dout !== 3'd4) begin n_err++; $display("FAIL mid_reach4 got %0d want 4", a_dout); end
        n_vec++; if (a_ovf !== 1'b1) begin n_err++; $display("FAIL mid_ovf_set got %b want 1", a_ovf); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++; if (a_dout !== 3'd0) begin n_err++; $display("FAIL mid_rst_data got %0d want 0", a_dout); end
        n_vec++; if (a_wrap !== 1'b0) begin n_err++; $display("FAIL mid_rst_wrap got %b want 0", a_wrap); end
        n_vec++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL mid_rst_ovf got %b want 0", a_ovf); end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_vec++; if (a_dout !== 3'(i)) begin n_err++; $display("FAIL mid_resume got %0d want %0d", a_dout, i); end
        end
        a_en = 1'b0;
    endtask

    task automatic test_cascade();
        logic [5:0] exp_v = 6'd0;
        c_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            exp_v = exp_v + 6'd1;
            step();
            n_vec++; if ({c1_dout, c0_dout} !== exp_v) begin n_err++; $display("FAIL cascade step %0d got %0d want %0d", i, {c1_dout, c0_dout}, exp_v); end
        end
        c_en = 1'b0;
        n_vec++; if (c1_wrap !== 1'b1) begin n_err++; $display("FAIL cascade_hi_wrap got %b want 1", c1_wrap); end
        n_vec++; if (c0_ovf !== 1'b1) begin n_err++; $display("FAIL cascade_lo_ovf got %b want 1", c0_ovf); end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down_mod6();
        test_saturate();
        test_priority();
        test_direction_hold();
        test_reset_mid();
        test_cascade();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
